psync_tx: RTL and testbench
===========================

Name: psync_tx

Overview:
- Source-side transmitter for the toggle-based pulse crossing.
- Accepts single-cycle event pulses in the source clock domain and queues them in a saturating pending counter.
- Launches each event as one level toggle on req_toggle. The destination edge detector converts each toggle back into a pulse.
- Waits for the destination's returned ack toggle before launching the next event, so no event is lost however close together the pulses arrive.

Parameters:
- CNT_W, 4, width of the pending-event counter; capacity 2^CNT_W-1.
- SYNC_STAGES, 2, flops in the ack_toggle synchronizer; legal range 2..4.
- TO_W, 8, width of the ack timeout counter; used only with PSYNC_TX_TIMEOUT_EN.

Ports:
- clk  in  1  source-domain clock.
- rst  in  1  synchronous reset, active-high.
- sin  in  1  event pulse; every high cycle is one event.
- req_toggle  out  1  registered toggle to the destination domain; flips once per launched event.
- ack_toggle  in  1  toggle from the destination domain, asynchronous to clk; follows req_toggle.
- busy  out  1  high while in WAIT_ACK or while pending != 0.
- pending  out  CNT_W  queued events not yet launched.
- overflow  out  1  sticky; set when an event is dropped at a full counter.
- ovf_clr  in  1  clears overflow.

Behaviour:
- Reset (rst high at a clk edge) gives:
  - req_toggle=0, synchronizer flops=0, state=IDLE, pending=0, overflow=0, busy=0.
  - timeout state cleared.
- Reset mid-handshake abandons the in-flight event. The destination must be reset in the same window.
- ack_s is ack_toggle after SYNC_STAGES flops.
- States:
  - IDLE -> WAIT_ACK when (sin | pending!=0). Same edge: req_toggle <= ~req_toggle.
  - WAIT_ACK -> IDLE when ack_s == req_toggle.
- Launch priority:
  - IDLE with pending!=0: launch from the queue (pending decrements). A concurrent sin increments, so the net count is unchanged.
  - IDLE with pending==0 and sin high: launch sin directly; pending stays 0.
  - WAIT_ACK with sin high: pending increments.
- Counter boundaries:
  - pending saturates at 2^CNT_W-1.
  - sin at a full counter with no concurrent decrement: event dropped, overflow <= 1.
  - sin at a full counter with a concurrent decrement: event not dropped.
- overflow:
  - ovf_clr clears it.
  - Set has priority over clear in the same cycle.
- Latency:
  - sin at edge N in IDLE, queue empty: req_toggle flips at edge N+1.
  - Ack returned: minimum round trip is destination sync plus SYNC_STAGES source cycles, then 1 cycle to IDLE.
  - Back-to-back launches are spaced at least SYNC_STAGES+2 cycles apart.
- busy is combinational from state and pending. No glitch concern: it is used in the source domain only.
- req_toggle comes directly from a flop, with no logic after it, so it is safe to cross domains.

Optional Feature:
- Macro PSYNC_TX_TIMEOUT_EN.
- Defined:
  - A TO_W-bit counter runs in WAIT_ACK and reloads to 0 on entry.
  - On reaching all-ones without an ack: state -> IDLE, req_toggle is forced equal to ack_s, and the sticky output ack_timeout (1 bit, cleared by ovf_clr) is set.
  - The event is counted as lost; pending is not restored.
- Undefined: no counter, no ack_timeout port, WAIT_ACK waits indefinitely.

Decomposition:
- Package psync_pkg holds:
  - the state enum {IDLE, WAIT_ACK};
  - the localparam PEND_MAX = 2^CNT_W-1 helper function.
- One sub-module, sync_srst:
  - N-stage synchronizer with synchronous active-high reset, parameter STAGES.
  - Instantiated once for ack_toggle.

Test Plan:
- Single event: reset, sin high for 1 cycle at cycle 10; ack loopback delayed by 3 cycles -> req_toggle 0->1 at cycle 11, busy high until ack_s matches, then pending=0, overflow=0.
- Burst: sin high for 5 consecutive cycles from IDLE; ack delay 3 -> 5 toggles total, pending peaks at 4, each toggle at least SYNC_STAGES+2 cycles apart, final req_toggle=1.
- Saturation: CNT_W=2, ack held static, 6 sin pulses -> 1 launched, pending=3, 2 dropped, overflow=1. Release ack -> 3 more toggles. ovf_clr -> overflow=0.
- Simultaneous events: IDLE with pending=3 (max) and sin high on the launch edge -> pending stays 3, overflow stays 0.
- Reset mid-handshake: assert rst while in WAIT_ACK with pending=2 -> next edge has req_toggle=0, pending=0, busy=0. A following single sin produces exactly one toggle.
- Timeout (PSYNC_TX_TIMEOUT_EN, TO_W=4): 1 event, ack never returns -> ack_timeout=1 on the 15th WAIT_ACK cycle, state IDLE, req_toggle==ack_s.

Source files
------------

// File: rtl/psync_pkg.sv
// rtl/psync_pkg.sv - shared state type and helpers for the psync_tx pulse-crossing transmitter
package psync_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } psync_state_t;

  // Largest value a cnt_w-bit pending counter can hold.
  function automatic int pend_max(input int cnt_w);
    return (1 << cnt_w) - 1;
  endfunction

endpackage

// File: rtl/psync_tx_sync_srst.sv
// rtl/psync_tx_sync_srst.sv - N-stage level synchronizer with synchronous active-high reset
module sync_srst
  import psync_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the asynchronous input one stage further down the chain each cycle.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // Synchronizer flops; reset clears the whole chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/psync_tx.sv
// rtl/psync_tx.sv - toggle-based pulse-crossing transmitter; optional ack timeout under PSYNC_TX_TIMEOUT_EN
module psync_tx
  import psync_pkg::*;
#(
  parameter int CNT_W       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TO_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  output logic             req_toggle,
  input  logic             ack_toggle,
  output logic             busy,
  output logic [CNT_W-1:0] pending,
  output logic             overflow,
  input  logic             ovf_clr
`ifdef PSYNC_TX_TIMEOUT_EN
  ,
  output logic             ack_timeout
`endif
);

  localparam logic [CNT_W-1:0] PEND_MAX = CNT_W'(pend_max(CNT_W));

  // Elaboration-time guard: the synchronizer needs at least two stages.
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || TO_W < 2 || CNT_W < 1) begin : g_bad_params
    $error("psync_tx: SYNC_STAGES must be 2..4, TO_W >= 2, CNT_W >= 1");
  end

  psync_state_t     state_q, state_d;
  logic             req_q, req_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             ovf_q, ovf_d;

  logic ack_s;
  logic ack_match;
  logic launch;
  logic pend_inc;
  logic pend_dec;
  logic pend_full;
  logic drop;
  logic timeout;

  sync_srst #(
    .STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .clk(clk),
    .rst(rst),
    .d  (ack_toggle),
    .q  (ack_s)
  );

  // Decode launch and queue movements. A sin that is not launched directly goes into the queue.
  always_comb begin
    ack_match = (ack_s == req_q);
    launch    = (state_q == IDLE) && (sin || (pend_q != '0));
    pend_dec  = (state_q == IDLE) && (pend_q != '0);
    pend_inc  = sin && !((state_q == IDLE) && (pend_q == '0));
    pend_full = (pend_q == PEND_MAX);
    drop      = pend_inc && pend_full && !pend_dec;
  end

`ifdef PSYNC_TX_TIMEOUT_EN
  logic [TO_W-1:0] to_q, to_d;
  logic            ato_q, ato_d;

  // Ack watchdog: counts WAIT_ACK cycles and fires on the edge the count reaches all-ones.
  always_comb begin
    to_d    = '0;
    timeout = 1'b0;
    if (state_q == WAIT_ACK) begin
      to_d    = to_q + 1'b1;
      timeout = !ack_match && (to_d == '1);
    end
    ato_d = ato_q;
    if (timeout) begin
      ato_d = 1'b1;
    end else if (ovf_clr) begin
      ato_d = 1'b0;
    end
  end

  // Watchdog registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_q  <= '0;
      ato_q <= 1'b0;
    end else begin
      to_q  <= to_d;
      ato_q <= ato_d;
    end
  end

  assign ack_timeout = ato_q;
`else
  assign timeout = 1'b0;
`endif

  // FSM next state: one launch per handshake, return to IDLE once the ack catches up.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (launch) begin
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ack_match || timeout) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: toggle on launch, resync toggle on timeout, saturating queue, sticky overflow.
  always_comb begin
    req_d = req_q;
    if (launch) begin
      req_d = ~req_q;
    end else if (timeout) begin
      // The lost event is abandoned; realign so the next launch is a clean toggle.
      req_d = ack_s;
    end

    pend_d = pend_q;
    if (!drop) begin
      if (pend_inc && !pend_dec) begin
        pend_d = pend_q + 1'b1;
      end else if (pend_dec && !pend_inc) begin
        pend_d = pend_q - 1'b1;
      end
    end

    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  // FSM outputs; req_toggle leaves straight from its flop so it can cross domains.
  always_comb begin
    busy       = (state_q == WAIT_ACK) || (pend_q != '0);
    req_toggle = req_q;
    pending    = pend_q;
    overflow   = ovf_q;
  end

endmodule

// File: tb/tb_psync_tx.sv
// tb/tb_psync_tx.sv - directed self-checking bench for psync_tx
module tb_psync_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       sin = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       ack_toggle, req_toggle, busy, overflow;
  logic [3:0] pending;

  logic       sin2 = 1'b0;
  logic       ovf_clr2 = 1'b0;
  logic       ack2, req2, busy2, overflow2;
  logic [1:0] pending2;

`ifdef PSYNC_TX_TIMEOUT_EN
  logic ack_timeout, ack_timeout2;
`endif

  logic [2:0] pipe, pipe2;
  logic       hold = 1'b0;
  logic       hold2 = 1'b0;

  int   checks = 0;
  int   passed = 0;
  int   cyc = 0;
  int   ntog, ntog2, last_tog, min_gap, peak;
  logic req_prev, req_prev2;

  psync_tx #(.CNT_W(4), .SYNC_STAGES(2), .TO_W(4)) dut (
    .clk(clk), .rst(rst), .sin(sin), .req_toggle(req_toggle), .ack_toggle(ack_toggle),
    .busy(busy), .pending(pending), .overflow(overflow), .ovf_clr(ovf_clr)
`ifdef PSYNC_TX_TIMEOUT_EN
    , .ack_timeout(ack_timeout)
`endif
  );

  psync_tx #(.CNT_W(2), .SYNC_STAGES(2), .TO_W(8)) dut2 (
    .clk(clk), .rst(rst), .sin(sin2), .req_toggle(req2), .ack_toggle(ack2),
    .busy(busy2), .pending(pending2), .overflow(overflow2), .ovf_clr(ovf_clr2)
`ifdef PSYNC_TX_TIMEOUT_EN
    , .ack_timeout(ack_timeout2)
`endif
  );

  // Destination model: ack follows req three cycles later unless held at 0.
  always @(posedge clk) begin
    if (rst) begin
      pipe  <= '0;
      pipe2 <= '0;
    end else begin
      pipe  <= {pipe[1:0], req_toggle};
      pipe2 <= {pipe2[1:0], req2};
    end
  end
  assign ack_toggle = hold  ? 1'b0 : pipe[2];
  assign ack2       = hold2 ? 1'b0 : pipe2[2];

  task automatic clear_stats();
    ntog = 0; ntog2 = 0; last_tog = -1; min_gap = 1000; peak = 0;
    req_prev = 1'b0; req_prev2 = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    cyc++;
    if (req_toggle !== req_prev) begin
      ntog++;
      if (last_tog >= 0 && (cyc - last_tog) < min_gap) min_gap = cyc - last_tog;
      last_tog = cyc;
    end
    req_prev = req_toggle;
    if (req2 !== req_prev2) ntog2++;
    req_prev2 = req2;
    if (int'(pending) > peak) peak = int'(pending);
  endtask

  task automatic do_reset();
    rst = 1'b1; sin = 1'b0; sin2 = 1'b0; ovf_clr = 1'b0; ovf_clr2 = 1'b0;
    hold = 1'b0; hold2 = 1'b0;
    tick(); tick();
    rst = 1'b0;
    clear_stats();
  endtask

  task automatic wait_idle(input int max_cyc);
    for (int i = 0; i < max_cyc && (busy === 1'b1 || busy2 === 1'b1); i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; sin = 1'b1; sin2 = 1'b1;
    tick(); tick();
    checks++; if (req_toggle !== 1'b0) $display("FAIL reset_req: got %b want 0", req_toggle); else passed++;
    checks++; if (pending !== 4'd0) $display("FAIL reset_pending: got %0d want 0", pending); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow); else passed++;
    checks++; if (pending2 !== 2'd0) $display("FAIL reset_pending2: got %0d want 0", pending2); else passed++;
    sin = 1'b0; sin2 = 1'b0; rst = 1'b0;
    clear_stats();
  endtask

  task automatic test_single();
    do_reset();
    repeat (8) tick();
    sin = 1'b1; tick(); sin = 1'b0;
    checks++; if (req_toggle !== 1'b1) $display("FAIL single_launch_req: got %b want 1", req_toggle); else passed++;
    checks++; if (busy !== 1'b1) $display("FAIL single_launch_busy: got %b want 1", busy); else passed++;
    checks++; if (pending !== 4'd0) $display("FAIL single_launch_pending: got %0d want 0", pending); else passed++;
    repeat (5) tick();
    checks++; if (busy !== 1'b1) $display("FAIL single_busy_before_idle: got %b want 1", busy); else passed++;
    tick();
    checks++; if (busy !== 1'b0) $display("FAIL single_busy_idle: got %b want 0", busy); else passed++;
    checks++; if (pending !== 4'd0) $display("FAIL single_pending_end: got %0d want 0", pending); else passed++;
    checks++; if (overflow !== 1'b0) $display("FAIL single_overflow: got %b want 0", overflow); else passed++;
    checks++; if (ntog !== 1) $display("FAIL single_toggles: got %0d want 1", ntog); else passed++;
  endtask

  task automatic test_burst();
    do_reset();
    sin = 1'b1; repeat (5) tick(); sin = 1'b0;
    wait_idle(80);
    checks++; if (ntog !== 5) $display("FAIL burst_toggles: got %0d want 5", ntog); else passed++;
    checks++; if (peak !== 4) $display("FAIL burst_peak: got %0d want 4", peak); else passed++;
    checks++; if (min_gap !== 7) $display("FAIL burst_min_gap: got %0d want 7", min_gap); else passed++;
    checks++; if (req_toggle !== 1'b1) $display("FAIL burst_final_req: got %b want 1", req_toggle); else passed++;
    checks++; if (pending !== 4'd0) $display("FAIL burst_pending_end: got %0d want 0", pending); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL burst_busy_end: got %b want 0", busy); else passed++;
  endtask

  task automatic test_saturation();
    do_reset();
    hold2 = 1'b1;
    sin2 = 1'b1; repeat (6) tick(); sin2 = 1'b0;
    tick();
    checks++; if (ntog2 !== 1) $display("FAIL sat_toggles_held: got %0d want 1", ntog2); else passed++;
    checks++; if (pending2 !== 2'd3) $display("FAIL sat_pending: got %0d want 3", pending2); else passed++;
    checks++; if (overflow2 !== 1'b1) $display("FAIL sat_overflow: got %b want 1", overflow2); else passed++;
    checks++; if (busy2 !== 1'b1) $display("FAIL sat_busy: got %b want 1", busy2); else passed++;
    hold2 = 1'b0;
    wait_idle(80);
    checks++; if (ntog2 !== 4) $display("FAIL sat_toggles_release: got %0d want 4", ntog2); else passed++;
    checks++; if (pending2 !== 2'd0) $display("FAIL sat_pending_drain: got %0d want 0", pending2); else passed++;
    checks++; if (overflow2 !== 1'b1) $display("FAIL sat_overflow_sticky: got %b want 1", overflow2); else passed++;
    checks++; if (req2 !== 1'b0) $display("FAIL sat_final_req: got %b want 0", req2); else passed++;
    ovf_clr2 = 1'b1; tick(); ovf_clr2 = 1'b0;
    checks++; if (overflow2 !== 1'b0) $display("FAIL sat_ovf_clr: got %b want 0", overflow2); else passed++;
  endtask

  task automatic test_simultaneous();
    do_reset();
    hold2 = 1'b1;
    sin2 = 1'b1; repeat (4) tick(); sin2 = 1'b0;
    tick();
    checks++; if (pending2 !== 2'd3) $display("FAIL simul_setup_pending: got %0d want 3", pending2); else passed++;
    hold2 = 1'b0;
    repeat (3) tick();
    sin2 = 1'b1; tick(); sin2 = 1'b0;
    checks++; if (pending2 !== 2'd3) $display("FAIL simul_pending: got %0d want 3", pending2); else passed++;
    checks++; if (overflow2 !== 1'b0) $display("FAIL simul_overflow: got %b want 0", overflow2); else passed++;
    checks++; if (ntog2 !== 2) $display("FAIL simul_toggles: got %0d want 2", ntog2); else passed++;
    wait_idle(80);
  endtask

  task automatic test_reset_mid();
    do_reset();
    hold = 1'b1;
    sin = 1'b1; repeat (3) tick(); sin = 1'b0;
    tick();
    checks++; if (pending !== 4'd2) $display("FAIL rmid_setup_pending: got %0d want 2", pending); else passed++;
    checks++; if (busy !== 1'b1) $display("FAIL rmid_setup_busy: got %b want 1", busy); else passed++;
    rst = 1'b1; tick();
    checks++; if (req_toggle !== 1'b0) $display("FAIL rmid_req: got %b want 0", req_toggle); else passed++;
    checks++; if (pending !== 4'd0) $display("FAIL rmid_pending: got %0d want 0", pending); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL rmid_busy: got %b want 0", busy); else passed++;
    rst = 1'b0; hold = 1'b0;
    clear_stats();
    tick(); tick();
    sin = 1'b1; tick(); sin = 1'b0;
    wait_idle(40);
    checks++; if (ntog !== 1) $display("FAIL rmid_after_toggles: got %0d want 1", ntog); else passed++;
    checks++; if (req_toggle !== 1'b1) $display("FAIL rmid_after_req: got %b want 1", req_toggle); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL rmid_after_busy: got %b want 0", busy); else passed++;
  endtask

`ifdef PSYNC_TX_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    hold = 1'b1;
    sin = 1'b1; tick(); sin = 1'b0;
    repeat (14) tick();
    checks++; if (ack_timeout !== 1'b0) $display("FAIL to_early: got %b want 0", ack_timeout); else passed++;
    checks++; if (busy !== 1'b1) $display("FAIL to_busy_wait: got %b want 1", busy); else passed++;
    tick();
    checks++; if (ack_timeout !== 1'b1) $display("FAIL to_fire: got %b want 1", ack_timeout); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL to_idle: got %b want 0", busy); else passed++;
    checks++; if (req_toggle !== 1'b0) $display("FAIL to_req_realign: got %b want 0", req_toggle); else passed++;
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    checks++; if (ack_timeout !== 1'b0) $display("FAIL to_clr: got %b want 0", ack_timeout); else passed++;
    hold = 1'b0;
  endtask
`endif

  initial begin
    clear_stats();
    test_reset();
    test_single();
    test_burst();
    test_saturation();
    test_simultaneous();
    test_reset_mid();
`ifdef PSYNC_TX_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
